biquad_sequencer: RTL and testbench
===================================

// Module: biquad_sequencer
// PURPOSE
//  Time-multiplexed scheduler for a cascade of NSEC direct-form-I biquad sections sharing one MAC.
//  Per accepted input sample it steps through the five taps of each section and saturates each section output.
//  It then shifts the section histories and emits one filtered sample.
//  Owns the coefficient store and a host write port; sits between the audio sample source and the channel-strip output stage.
// PARAMETERS
//  NSEC  2   number of cascaded biquad sections (1..8)
//  CW    32  coefficient width, signed Q2.(FRAC)
//  FRAC  30  coefficient fraction bits; products are arithmetically shifted right by FRAC
//  AW    4   coef_addr width; must satisfy 2**AW >= 5*NSEC
// PORTS
//  clk          in   1     system clock, rising edge
//  reset_n      in   1     asynchronous active-low reset
//  sample_in    in   16    signed input sample
//  sample_valid in   1     single-cycle strobe, sample_in valid
//  filter_en    in   1     1 = filter, 0 = bypass
//  coef_we      in   1     coefficient write strobe
//  coef_addr    in   AW    addr = sec*5 + tap; tap 0..4 = b0,b1,b2,a1,a2
//  coef_wdata   in   CW    signed coefficient
//  coef_ready   out  1     = ~busy; a write is accepted only when coef_ready=1
//  overrun_clr  in   1     clears the overrun flag
//  sample_out   out  16    signed filtered sample, held between updates
//  out_valid    out  1     one-cycle pulse, sample_out is new
//  busy         out  1     sequencer is not IDLE
//  overrun      out  1     sticky: a sample_valid was dropped
// BEHAVIOUR
//  Reset (asynchronous, at any time, including mid-sequence):
//   - sample_out=0, out_valid=0, busy=0, overrun=0; FSM goes to IDLE; all histories x1,x2,y1,y2 = 0.
//   - Coefficients reset to identity: b0 = 2**FRAC, all others 0. The whole cascade is then passthrough.
//  FSM states:
//   - IDLE: sample_valid with filter_en=1 latches sample_in and sets sec=0, tap=0; next state MAC.
//   - MAC: one tap per cycle, acc += coef[sec][tap]*operand. Operand order is x0, x1, x2, y1, y2. After tap 4, go to UPDATE.
//   - UPDATE: y = sat16(acc >>> FRAC); x2<=x1, x1<=x0, y2<=y1, y1<=y; y becomes x0 of sec+1; acc is cleared.
//     If sec < NSEC-1, go to MAC with sec+1. Otherwise, sample_out<=y, out_valid<=1, go to IDLE.
//  Arithmetic:
//   - Difference equation: y = b0*x0 + b1*x1 + b2*x2 + a1*y1 + a2*y2. Feedback coefficients are stored pre-negated and are added.
//   - Products are full width (16+CW). The accumulator is 16+CW+3 bits and never wraps. One arithmetic shift (floor) is applied after summation.
//   - sat16 clamps to [-32768, 32767]. Histories store the saturated 16-bit values.
//  Latency:
//   - out_valid is high in the cycle after the 6*NSEC-th rising edge following the edge that accepted sample_valid. With NSEC=2 that is 12 edges.
//   - busy is high from the accept edge until the edge that raises out_valid. Throughput is one sample per 6*NSEC+1 cycles.
//  Bypass (filter_en=0 in IDLE):
//   - sample_out<=sample_in and out_valid<=1 on the next edge. No MAC cycles run; histories are unchanged.
//   - filter_en is sampled only at the accept edge.
//  Overrun:
//   - sample_valid while busy=1 drops that sample and sets overrun.
//   - If overrun_clr and a drop occur in the same cycle, set wins.
//  Coefficient writes:
//   - A write is accepted when coef_we=1 and busy=0. A write while busy is ignored; the host holds the write until coef_ready=1.
//   - addr >= 5*NSEC is ignored.
//   - A write and sample_valid on the same IDLE edge are both accepted; the new coefficient applies to that sample.
// TESTING
//  1 Reset, then sample 1000 with NSEC=2 -> out_valid pulse exactly 12 cycles later with sample_out=1000; busy high for 12 cycles.
//  2 Write sec0 b0=b1=2**29; impulse 16384 then zeros -> outputs 8192, 8192, 0, 0.
//  3 Write sec0 a1=2**29 (b0=1.0); step input of 1000 -> outputs 1000, 1500, 1750, 1875 (floor).
//  4 Write sec0 b0=1610612736 (1.5); input 30000 -> 32767; input -30000 -> -32768. Confirm the clamped value propagates through sec1.
//  5 Assert sample_valid 3 cycles after an accept -> sample dropped, overrun=1, exactly one out_valid.
//    coef_we while busy -> no change. overrun_clr -> 0.
//  6 Deassert reset_n at cycle 7 of a sequence -> no out_valid; busy=0; coefficients back to identity; next sample passes unchanged.

Source files
------------

// File: rtl/biquad_sequencer.sv
// Cascade of NSEC direct-form-I biquads evaluated on one shared multiply-accumulate,
// five taps per section followed by a saturating update cycle.
module biquad_sequencer #(
  parameter int NSEC = 2,
  parameter int CW   = 32,
  parameter int FRAC = 30,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [15:0]   sample_in,
  input  logic                 sample_valid,
  input  logic                 filter_en,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 coef_ready,
  input  logic                 overrun_clr,
  output logic signed [15:0]   sample_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int NCOEF = 5 * NSEC;
  localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int PW    = 16 + CW;
  localparam int ACCW  = PW + 3;
  localparam logic signed [CW-1:0] COEF_ONE = CW'(1) << FRAC;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_UPDATE} state_t;

  state_t                r_state, w_next;
  logic [SW-1:0]         r_sec;
  logic [2:0]            r_tap;
  logic signed [CW-1:0]  r_coef [NCOEF];
  logic signed [15:0]    r_x1 [NSEC];
  logic signed [15:0]    r_x2 [NSEC];
  logic signed [15:0]    r_y1 [NSEC];
  logic signed [15:0]    r_y2 [NSEC];
  logic signed [15:0]    r_x0;
  logic signed [ACCW-1:0] r_acc;

  logic                  w_last_tap, w_last_sec, w_coef_wr;
  logic [AW-1:0]         w_cidx;
  logic signed [15:0]    w_opnd;
  logic signed [PW-1:0]  w_prod;
  logic signed [ACCW-1:0] w_sh;
  logic signed [15:0]    w_y;

  function automatic logic signed [15:0] sat16(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] hi, lo;
    hi = ACCW'(32767);
    lo = -ACCW'(32768);
    if (v > hi)      sat16 = 16'sh7FFF;
    else if (v < lo) sat16 = 16'sh8000;
    else             sat16 = v[15:0];
  endfunction

  assign w_last_tap = (r_tap == 3'd4);
  assign w_last_sec = (r_sec == SW'(NSEC - 1));
  assign w_coef_wr  = coef_we && !busy && (32'(coef_addr) < NCOEF);
  assign w_cidx     = AW'(r_sec) * AW'(5) + AW'(r_tap);
  assign w_prod     = PW'(w_opnd) * PW'(r_coef[w_cidx]);
  assign w_sh       = r_acc >>> FRAC;
  assign w_y        = sat16(w_sh);

  // Tap order x0, x1, x2, y1, y2; feedback coefficients are stored pre-negated.
  always_comb begin
    w_opnd = r_x0;
    case (r_tap)
      3'd1:    w_opnd = r_x1[r_sec];
      3'd2:    w_opnd = r_x2[r_sec];
      3'd3:    w_opnd = r_y1[r_sec];
      3'd4:    w_opnd = r_y2[r_sec];
      default: w_opnd = r_x0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (sample_valid && filter_en) w_next = S_MAC;
      S_MAC:    if (w_last_tap) w_next = S_UPDATE;
      S_UPDATE: w_next = w_last_sec ? S_IDLE : S_MAC;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    coef_ready = !busy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sec      <= '0;
      r_tap      <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NCOEF; i++) r_coef[i] <= (i % 5 == 0) ? COEF_ONE : '0;
      for (int s = 0; s < NSEC; s++) begin
        r_x1[s] <= '0;
        r_x2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (sample_valid && busy) overrun <= 1'b1;
      else if (overrun_clr)     overrun <= 1'b0;
      if (w_coef_wr) r_coef[coef_addr] <= coef_wdata;
      case (r_state)
        S_IDLE: begin
          if (sample_valid) begin
            if (filter_en) begin
              r_sec <= '0;
              r_tap <= '0;
            end else begin
              sample_out <= sample_in;
              out_valid  <= 1'b1;
            end
          end
        end
        S_MAC: if (!w_last_tap) r_tap <= r_tap + 3'd1;
        S_UPDATE: begin
          r_x2[r_sec] <= r_x1[r_sec];
          r_x1[r_sec] <= r_x0;
          r_y2[r_sec] <= r_y1[r_sec];
          r_y1[r_sec] <= w_y;
          r_tap       <= '0;
          if (!w_last_sec) begin
            r_sec <= r_sec + SW'(1);
          end else begin
            sample_out <= w_y;
            out_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Section input and accumulator are fully rewritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (sample_valid && filter_en) begin
          r_x0  <= sample_in;
          r_acc <= '0;
        end
      end
      S_MAC:    r_acc <= r_acc + ACCW'(w_prod);
      S_UPDATE: begin
        r_x0  <= w_y;
        r_acc <= '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_biquad_sequencer.sv
// Directed bench for biquad_sequencer: expected outputs are queued at issue time
// and a negedge monitor pops one per out_valid pulse.
module tb_biquad_sequencer;

  localparam int NSEC = 2;
  localparam int CW   = 32;
  localparam int FRAC = 30;
  localparam int AW   = 4;
  localparam int ONE  = 32'h4000_0000;
  localparam int HALF = 32'h2000_0000;

  logic                 clk;
  logic                 reset_n;
  logic signed [15:0]   sample_in;
  logic                 sample_valid;
  logic                 filter_en;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic                 coef_ready;
  logic                 overrun_clr;
  logic signed [15:0]   sample_out;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  biquad_sequencer #(.NSEC(NSEC), .CW(CW), .FRAC(FRAC), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .filter_en(filter_en), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_ready(coef_ready), .overrun_clr(overrun_clr),
    .sample_out(sample_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got sample_out %0d, expected no output", sample_out);
      end else begin
        check("sample_out", sample_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #7;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wcoef(input int addr, input int data);
    int n = 0;
    while (!coef_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("coef_ready_timeout", n, 0);
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = CW'(data);
    tick();
    coef_we = 1'b0;
  endtask

  // Issues one sample and checks the edge count to out_valid and the busy window.
  task automatic send(input int v, input bit en, input int exp);
    int n = 0;
    int nb = 0;
    int lat;
    lat = en ? 6 * NSEC : 0;
    exp_q.push_back(exp);
    sample_in    = 16'(v);
    filter_en    = en;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    coef_we      = 1'b0;
    while (!out_valid && n < 100) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check("latency", n, lat);
    check("busy_cycles", nb, lat);
    tick();
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    filter_en    = 1'b1;
    coef_we      = 1'b0;
    coef_addr    = '0;
    coef_wdata   = '0;
    overrun_clr  = 1'b0;
    #3;
    check("rst_sample_out", sample_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_coef_ready", coef_ready, 1);
    #10;
    reset_n = 1'b1;
    tick();

    // Identity cascade passes the sample through
    send(1000, 1'b1, 1000);

    // b0 = b1 = 0.5 in section 0
    apply_reset();
    wcoef(0, HALF);
    wcoef(1, HALF);
    send(16384, 1'b1, 8192);
    send(0, 1'b1, 8192);
    send(0, 1'b1, 0);
    send(0, 1'b1, 0);

    // a1 = 0.5 recursion; a bypass sample in the middle must not disturb history
    apply_reset();
    wcoef(3, HALF);
    send(1000, 1'b1, 1000);
    send(1000, 1'b1, 1500);
    send(7777, 1'b0, 7777);
    send(1000, 1'b1, 1750);
    send(1000, 1'b1, 1875);

    // Saturation in section 0, then scaled by section 1
    apply_reset();
    wcoef(0, 1610612736);
    send(30000, 1'b1, 32767);
    send(-30000, 1'b1, -32768);
    wcoef(5, HALF);
    send(30000, 1'b1, 16383);
    send(-30000, 1'b1, -16384);

    // Overrun, ignored write while busy, set-wins over clear
    apply_reset();
    exp_q.push_back(1000);
    sample_in    = 16'sd1000;
    filter_en    = 1'b1;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    sample_in    = 16'sd5555;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("overrun_set", overrun, 1);
    check("coef_ready_busy", coef_ready, 0);
    coef_we    = 1'b1;
    coef_addr  = '0;
    coef_wdata = '0;
    tick();
    coef_we      = 1'b0;
    sample_valid = 1'b1;
    overrun_clr  = 1'b1;
    tick();
    sample_valid = 1'b0;
    overrun_clr  = 1'b0;
    check("overrun_set_wins", overrun, 1);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check("drop_seq_done", out_valid, 1);
    tick();
    tick();
    check("overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 0);
    send(1234, 1'b1, 1234);

    // Reset in the middle of a sequence
    wcoef(0, HALF);
    sample_in    = 16'sd1000;
    filter_en    = 1'b1;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sample_out", sample_out, 0);
    #4;
    reset_n = 1'b1;
    repeat (20) tick();
    send(1000, 1'b1, 1000);

    // Coefficient write on the same edge as the accepted sample
    apply_reset();
    coef_we    = 1'b1;
    coef_addr  = '0;
    coef_wdata = CW'(HALF);
    send(1000, 1'b1, 500);
    send(-1001, 1'b1, -501);

    repeat (3) tick();
    check("outputs_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
